// File: rtl/fix_pkg.sv
// Shared types and constants for the FIX tag-10 checksum controller.
// Holds the FSM/error enums, the result record and the shift-add decimal helper.
package fix_pkg;

    localparam logic [7:0] SOH_DEFAULT = 8'h01;
    localparam logic [7:0] CH_ZERO     = 8'h30;
    localparam logic [7:0] CH_ONE      = 8'h31;
    localparam logic [7:0] CH_EQ       = 8'h3D;

    typedef enum logic [3:0] {
        IDLE, BODY, T1, T0, TEQ, D0, D1, D2, TERM, FLUSH
    } state_t;

    typedef enum logic [2:0] {
        ERR_OK       = 3'd0,
        ERR_MISMATCH = 3'd1,
        ERR_BADDIGIT = 3'd2,
        ERR_RANGE    = 3'd3,
        ERR_NOTERM   = 3'd4,
        ERR_TRUNC    = 3'd5
    } err_t;

    typedef struct packed {
        logic       pass;
        err_t       err;
        logic [7:0] calc;
        logic [7:0] rcv;
    } result_t;

    // d0*100 + d1*10 + d2 using only shifts and adds; max 999 fits in 10 bits
    function automatic logic [9:0] dec3(input logic [3:0] d0,
                                       input logic [3:0] d1,
                                       input logic [3:0] d2);
        logic [9:0] a, b, c;
        a = {6'd0, d0};
        b = {6'd0, d1};
        c = {6'd0, d2};
        return (a << 6) + (a << 5) + (a << 2) + (b << 3) + (b << 1) + c;
    endfunction

endpackage

// File: rtl/fix_ascii_digit.sv
// Combinational ASCII decimal digit decoder: value of '0'..'9' plus a validity flag.
module fix_ascii_digit
    import fix_pkg::*;
(
    input  logic [7:0] chr_i,
    output logic [3:0] val_o,
    output logic       is_digit_o
);

    assign is_digit_o = (chr_i >= CH_ZERO) && (chr_i <= (CH_ZERO + 8'd9));
    assign val_o      = chr_i[3:0];

endmodule

// File: rtl/fix_checksum_ctrl.sv
// FIX tag-10 checksum verifier: accumulates the mod-256 sum, parses the trailer digits
// and presents a held result record under a valid/ack handshake.
module fix_checksum_ctrl
    import fix_pkg::*;
#(
    parameter logic [7:0]  SOH_CHAR = SOH_DEFAULT,
    parameter int unsigned LEN_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       data_i,
    input  logic             valid_i,
    input  logic             sop_i,
    input  logic             eop_i,
    output logic             res_valid_o,
    input  logic             res_ack_i,
    output logic             pass_o,
    output logic [2:0]       err_o,
    output logic [7:0]       calc_sum_o,
    output logic [7:0]       rcv_sum_o,
    output logic [LEN_W-1:0] msg_len_o,
    output logic             overrun_o
);

    state_t           state_q, state_d;
    logic [7:0]       sum_q, sum_d;
    logic [7:0]       soh_q, soh_d;
    logic [7:0]       calc_q, calc_d;
    logic [3:0]       dg0_q, dg0_d, dg1_q, dg1_d, dg2_q, dg2_d;
    logic [LEN_W-1:0] len_q, len_d;

    logic             res_valid_q, res_valid_d;
    result_t          rec_q, rec_d;
    logic [LEN_W-1:0] olen_q, olen_d;
    logic             ovr_q, ovr_d;

    logic             rep_v;
    result_t          rep;
    logic [LEN_W-1:0] rep_len;

    logic [3:0]       dig_val;
    logic             dig_ok;
    logic [7:0]       sum_nx;
    logic [LEN_W-1:0] len_nx;
    logic [9:0]       rcv10;
    logic             is_soh;

    fix_ascii_digit u_digit (
        .chr_i      (data_i),
        .val_o      (dig_val),
        .is_digit_o (dig_ok)
    );

    assign sum_nx = sum_q + data_i;
    assign len_nx = (len_q == '1) ? len_q : len_q + LEN_W'(1);
    assign rcv10  = dec3(dg0_q, dg1_q, dg2_q);
    assign is_soh = (data_i == SOH_CHAR);

    always_comb begin
        state_d = state_q;
        sum_d   = sum_q;
        soh_d   = soh_q;
        calc_d  = calc_q;
        dg0_d   = dg0_q;
        dg1_d   = dg1_q;
        dg2_d   = dg2_q;
        len_d   = len_q;
        rep_v   = 1'b0;
        rep     = '0;
        rep_len = len_q;

        if (valid_i && sop_i) begin
            // A sop inside an active message aborts it; the same byte opens the next one
            if (state_q != IDLE && state_q != FLUSH) begin
                rep_v    = 1'b1;
                rep.err  = ERR_TRUNC;
                rep.calc = sum_q;
                rep_len  = len_q;
            end
            sum_d = data_i;
            len_d = LEN_W'(1);
            if (is_soh) begin
                state_d = T1;
                soh_d   = data_i;
            end else begin
                state_d = BODY;
            end
            if (eop_i) begin
                state_d = IDLE;
                if (!rep_v) begin
                    rep_v    = 1'b1;
                    rep.err  = ERR_TRUNC;
                    rep.calc = data_i;
                    rep_len  = LEN_W'(1);
                end
            end
        end else if (valid_i) begin
            case (state_q)
                IDLE: ;
                FLUSH: if (eop_i) state_d = IDLE;
                default: begin
                    sum_d = sum_nx;
                    len_d = len_nx;
                    case (state_q)
                        BODY, T1, T0, TEQ: begin
                            if (is_soh) begin
                                soh_d   = sum_nx;
                                state_d = T1;
                            end else if (state_q == T1 && data_i == CH_ONE) begin
                                state_d = T0;
                            end else if (state_q == T0 && data_i == CH_ZERO) begin
                                state_d = TEQ;
                            end else if (state_q == TEQ && data_i == CH_EQ) begin
                                state_d = D0;
                                calc_d  = soh_q;
                            end else begin
                                state_d = BODY;
                            end
                        end
                        D0, D1, D2: begin
                            if (dig_ok) begin
                                case (state_q)
                                    D0:      begin dg0_d = dig_val; state_d = D1;   end
                                    D1:      begin dg1_d = dig_val; state_d = D2;   end
                                    default: begin dg2_d = dig_val; state_d = TERM; end
                                endcase
                            end else begin
                                rep_v    = 1'b1;
                                rep.err  = ERR_BADDIGIT;
                                rep.calc = calc_q;
                                rep_len  = len_nx;
                                state_d  = eop_i ? IDLE : FLUSH;
                            end
                        end
                        TERM: begin
                            rep_v    = 1'b1;
                            rep.calc = calc_q;
                            rep.rcv  = rcv10[7:0];
                            rep_len  = len_nx;
                            state_d  = IDLE;
                            if (!is_soh) begin
                                rep.err = ERR_NOTERM;
                                state_d = eop_i ? IDLE : FLUSH;
                            end else if (rcv10 > 10'd255) begin
                                rep.err = ERR_RANGE;
                            end else if (rcv10[7:0] != calc_q) begin
                                rep.err = ERR_MISMATCH;
                            end else begin
                                rep.err  = ERR_OK;
                                rep.pass = 1'b1;
                            end
                        end
                        default: ;
                    endcase
                    // Digit/terminator errors on the eop byte take precedence over truncation
                    if (eop_i && !rep_v && state_q != TERM) begin
                        rep_v    = 1'b1;
                        rep.err  = ERR_TRUNC;
                        rep.calc = sum_nx;
                        rep_len  = len_nx;
                        state_d  = IDLE;
                    end
                end
            endcase
        end
    end

    always_comb begin
        res_valid_d = res_valid_q;
        rec_d       = rec_q;
        olen_d      = olen_q;
        ovr_d       = ovr_q;
        if (res_valid_q && res_ack_i) begin
            res_valid_d = 1'b0;
            ovr_d       = 1'b0;
        end
        if (rep_v) begin
            if (res_valid_q && !res_ack_i) begin
                ovr_d = 1'b1;
            end else begin
                res_valid_d = 1'b1;
                rec_d       = rep;
                olen_d      = rep_len;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sum_q       <= '0;
            soh_q       <= '0;
            calc_q      <= '0;
            dg0_q       <= '0;
            dg1_q       <= '0;
            dg2_q       <= '0;
            len_q       <= '0;
            res_valid_q <= 1'b0;
            rec_q       <= '0;
            olen_q      <= '0;
            ovr_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            sum_q       <= sum_d;
            soh_q       <= soh_d;
            calc_q      <= calc_d;
            dg0_q       <= dg0_d;
            dg1_q       <= dg1_d;
            dg2_q       <= dg2_d;
            len_q       <= len_d;
            res_valid_q <= res_valid_d;
            rec_q       <= rec_d;
            olen_q      <= olen_d;
            ovr_q       <= ovr_d;
        end
    end

    assign res_valid_o = res_valid_q;
    assign pass_o      = rec_q.pass;
    assign err_o       = rec_q.err;
    assign calc_sum_o  = rec_q.calc;
    assign rcv_sum_o   = rec_q.rcv;
    assign msg_len_o   = olen_q;
    assign overrun_o   = ovr_q;

endmodule

// File: tb/tb_fix_checksum_ctrl.sv
// Directed and randomized bench for fix_checksum_ctrl; expectations come from a
// string-level trailer search model rather than a state machine.
module tb_fix_checksum_ctrl;
    import fix_pkg::*;

    localparam int unsigned LW  = 5;
    localparam logic [7:0]  SOH = 8'h01;
    localparam int          LEN_MAX = (1 << LW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [7:0]    data_i = '0;
    logic          valid_i = 1'b0, sop_i = 1'b0, eop_i = 1'b0, res_ack_i = 1'b0;
    logic          res_valid_o, pass_o, overrun_o;
    logic [2:0]    err_o;
    logic [7:0]    calc_sum_o, rcv_sum_o;
    logic [LW-1:0] msg_len_o;

    int n_cmp = 0;
    int n_fail = 0;
    logic [7:0] msg_q[$];
    logic [7:0] alpha [7] = '{8'h01, 8'h31, 8'h30, 8'h3D, 8'h41, 8'h38, 8'h35};

    fix_checksum_ctrl #(.SOH_CHAR(SOH), .LEN_W(LW)) dut (
        .clk(clk), .rst_n(rst_n), .data_i(data_i), .valid_i(valid_i),
        .sop_i(sop_i), .eop_i(eop_i), .res_valid_o(res_valid_o), .res_ack_i(res_ack_i),
        .pass_o(pass_o), .err_o(err_o), .calc_sum_o(calc_sum_o), .rcv_sum_o(rcv_sum_o),
        .msg_len_o(msg_len_o), .overrun_o(overrun_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic s, input logic e);
        data_i = b; valid_i = 1'b1; sop_i = s; eop_i = e;
        @(posedge clk); #1;
        valid_i = 1'b0; sop_i = 1'b0; eop_i = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic push_str(input string s);
        for (int i = 0; i < s.len(); i++) msg_q.push_back(s[i]);
    endtask

    task automatic send_part(input bit first_sop, input bit last_eop, input int gap_max);
        int n;
        n = msg_q.size();
        for (int i = 0; i < n; i++) begin
            if (gap_max > 0) idle_cycles($urandom_range(gap_max, 0));
            send_byte(msg_q[i], first_sop && i == 0, last_eop && i == n - 1);
        end
    endtask

    task automatic ack(input string tag);
        res_ack_i = 1'b1;
        @(posedge clk); #1;
        res_ack_i = 1'b0;
        chk(tag, res_valid_o, 1'b0);
    endtask

    task automatic load_test1();
        msg_q.delete();
        push_str("8=A"); msg_q.push_back(SOH); push_str("10=183"); msg_q.push_back(SOH);
    endtask

    // Locate the first SOH,"10=" in the byte string and grade what follows it
    task automatic model(output logic [2:0] e_x, output logic [7:0] c_x,
                         output logic [7:0] r_x, output int n_x);
        int L, k, p, val;
        int unsigned tot, pre;
        bit done;
        L = msg_q.size(); k = -1; val = 0; tot = 0; pre = 0; done = 0;
        for (int i = 0; i < L; i++) tot += msg_q[i];
        for (int i = 0; i + 3 < L; i++)
            if (k < 0 && msg_q[i] == SOH && msg_q[i+1] == 8'h31 &&
                msg_q[i+2] == 8'h30 && msg_q[i+3] == 8'h3D) k = i;
        e_x = ERR_TRUNC; c_x = tot[7:0]; r_x = '0; n_x = L;
        if (k >= 0 && k + 3 < L - 1) begin
            for (int i = 0; i <= k; i++) pre += msg_q[i];
            c_x = pre[7:0];
            for (int j = 0; j < 3 && !done; j++) begin
                p = k + 4 + j;
                if (msg_q[p] < 8'h30 || msg_q[p] > 8'h39) begin
                    e_x = ERR_BADDIGIT; n_x = p + 1; done = 1;
                end else begin
                    val = val * 10 + int'(msg_q[p] - 8'h30);
                    if (p == L - 1) begin
                        e_x = ERR_TRUNC; c_x = tot[7:0]; n_x = L; done = 1;
                    end
                end
            end
            if (!done) begin
                p = k + 7; n_x = p + 1; r_x = val[7:0];
                if (msg_q[p] != SOH)          e_x = ERR_NOTERM;
                else if (val > 255)           e_x = ERR_RANGE;
                else if (val != int'(pre[7:0])) e_x = ERR_MISMATCH;
                else                          e_x = ERR_OK;
            end
        end
        if (n_x > LEN_MAX) n_x = LEN_MAX;
    endtask

    task automatic expect_model(input string tag);
        logic [2:0] e_x;
        logic [7:0] c_x, r_x;
        int n_x;
        model(e_x, c_x, r_x, n_x);
        for (int w = 0; w < 10 && !res_valid_o; w++) idle_cycles(1);
        chk({tag, "_valid"}, res_valid_o, 1'b1);
        chk({tag, "_err"}, err_o, e_x);
        chk({tag, "_pass"}, pass_o, e_x == ERR_OK);
        chk({tag, "_calc"}, calc_sum_o, c_x);
        if (e_x != ERR_BADDIGIT && e_x != ERR_NOTERM) chk({tag, "_rcv"}, rcv_sum_o, r_x);
        chk({tag, "_len"}, msg_len_o, n_x);
        chk({tag, "_ovr"}, overrun_o, 1'b0);
        ack({tag, "_ack"});
    endtask

    initial begin
        int nb, mode, cs;
        // reset state
        idle_cycles(2);
        chk("rst_valid", res_valid_o, 0); chk("rst_pass", pass_o, 0);
        chk("rst_err", err_o, 0); chk("rst_calc", calc_sum_o, 0);
        chk("rst_rcv", rcv_sum_o, 0); chk("rst_len", msg_len_o, 0);
        chk("rst_ovr", overrun_o, 0);
        rst_n = 1'b1;
        idle_cycles(1);

        // test 1: clean pass with latency check
        load_test1(); void'(msg_q.pop_back());
        send_part(1, 0, 0);
        chk("t1_pre_valid", res_valid_o, 0);
        send_byte(SOH, 0, 1);
        chk("t1_valid", res_valid_o, 1); chk("t1_pass", pass_o, 1);
        chk("t1_err", err_o, ERR_OK); chk("t1_calc", calc_sum_o, 8'hB7);
        chk("t1_rcv", rcv_sum_o, 8'hB7); chk("t1_len", msg_len_o, 11);
        ack("t1_ack");

        // test 2: mismatch, then overrun while held
        msg_q.delete();
        push_str("8=A"); msg_q.push_back(SOH); push_str("10=184"); msg_q.push_back(SOH);
        send_part(1, 1, 0);
        chk("t2_err", err_o, ERR_MISMATCH); chk("t2_pass", pass_o, 0);
        chk("t2_calc", calc_sum_o, 8'd183); chk("t2_rcv", rcv_sum_o, 8'd184);
        load_test1(); send_part(1, 1, 0);
        chk("t2_hold_valid", res_valid_o, 1); chk("t2_hold_err", err_o, ERR_MISMATCH);
        chk("t2_hold_rcv", rcv_sum_o, 8'd184); chk("t2_ovr", overrun_o, 1);
        ack("t2_ack");
        chk("t2_ovr_clr", overrun_o, 0);

        // test 3: "110=" inside the body is not a trailer
        msg_q.delete();
        push_str("8=A"); msg_q.push_back(SOH); push_str("110=5"); msg_q.push_back(SOH);
        push_str("10=188"); msg_q.push_back(SOH);
        send_part(1, 1, 1);
        chk("t3_err", err_o, ERR_OK); chk("t3_calc", calc_sum_o, 8'hBC);
        chk("t3_len", msg_len_o, 17);
        ack("t3_ack");

        // test 4: bad digit flushes until eop; then range overflow
        msg_q.delete();
        push_str("8=A"); msg_q.push_back(SOH); push_str("10=2x");
        send_part(1, 0, 0);
        chk("t4_bd_valid", res_valid_o, 1); chk("t4_bd_err", err_o, ERR_BADDIGIT);
        chk("t4_bd_len", msg_len_o, 9);
        ack("t4_bd_ack");
        msg_q.delete(); push_str("7"); msg_q.push_back(SOH); push_str("ZZ");
        send_part(0, 1, 0);
        chk("t4_flush_quiet", res_valid_o, 0);
        msg_q.delete();
        push_str("8=A"); msg_q.push_back(SOH); push_str("10=300"); msg_q.push_back(SOH);
        send_part(1, 1, 0);
        chk("t4_rg_err", err_o, ERR_RANGE); chk("t4_rg_rcv", rcv_sum_o, 8'h2C);
        chk("t4_rg_calc", calc_sum_o, 8'hB7);
        ack("t4_rg_ack");

        // test 5: restart mid-message, then eop truncation
        msg_q.delete();
        push_str("8=A"); msg_q.push_back(SOH); push_str("10");
        send_part(1, 0, 0);
        send_byte(8'h38, 1, 0);
        chk("t5_tr_valid", res_valid_o, 1); chk("t5_tr_err", err_o, ERR_TRUNC);
        chk("t5_tr_calc", calc_sum_o, 8'h18); chk("t5_tr_rcv", rcv_sum_o, 0);
        ack("t5_tr_ack");
        load_test1(); void'(msg_q.pop_front());
        send_part(0, 1, 0);
        chk("t5_b_pass", pass_o, 1); chk("t5_b_len", msg_len_o, 11);
        ack("t5_b_ack");
        msg_q.delete(); push_str("8=A");
        send_part(1, 1, 0);
        chk("t5_eop_err", err_o, ERR_TRUNC); chk("t5_eop_calc", calc_sum_o, 8'hB6);
        chk("t5_eop_len", msg_len_o, 3);

        // test 6: asynchronous reset while parsing digits, record still held
        msg_q.delete();
        push_str("8=A"); msg_q.push_back(SOH); push_str("10=1");
        send_part(1, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_valid", res_valid_o, 0); chk("t6_err", err_o, 0);
        chk("t6_calc", calc_sum_o, 0); chk("t6_len", msg_len_o, 0);
        #2 rst_n = 1'b1;
        idle_cycles(1);
        load_test1(); send_part(1, 1, 0);
        chk("t6_after_pass", pass_o, 1); chk("t6_after_valid", res_valid_o, 1);
        ack("t6_ack");

        // length counter saturation
        msg_q.delete();
        for (int i = 0; i < 40; i++) msg_q.push_back(8'h41);
        send_part(1, 1, 0);
        chk("sat_len", msg_len_o, LEN_MAX); chk("sat_calc", calc_sum_o, 8'h28);
        ack("sat_ack");

        // randomized messages graded by the string model
        for (int m = 0; m < 60; m++) begin
            msg_q.delete();
            nb = $urandom_range(6, 0);
            for (int i = 0; i < nb; i++) msg_q.push_back(alpha[$urandom_range(6, 0)]);
            if ($urandom_range(9, 0) < 8) begin
                msg_q.push_back(SOH); push_str("10=");
                cs = 0;
                foreach (msg_q[i]) cs += msg_q[i];
                cs = cs % 256;
                mode = $urandom_range(3, 0);
                for (int j = 0; j < 3; j++) begin
                    case (mode)
                        0, 1: msg_q.push_back(8'h30 + 8'((j == 0) ? cs / 100 : (j == 1) ? (cs / 10) % 10 : cs % 10));
                        2:    msg_q.push_back(8'h30 + 8'($urandom_range(9, 0)));
                        default: msg_q.push_back(8'($urandom_range(255, 0)));
                    endcase
                end
                if ($urandom_range(9, 0) < 8) msg_q.push_back(SOH);
                else msg_q.push_back(alpha[$urandom_range(6, 1)]);
            end
            nb = $urandom_range(2, 0);
            for (int i = 0; i < nb; i++) msg_q.push_back(alpha[$urandom_range(6, 0)]);
            if (msg_q.size() == 0) msg_q.push_back(8'h41);
            send_part(1, 1, 2);
            expect_model($sformatf("rnd%0d", m));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
